// File: rtl/rot_word_fetcher_pkg.sv
// rot_word_fetcher_pkg: shared defaults, FSM states and start-offset type for rot_word_fetcher
package rot_word_fetcher_pkg;
  localparam int WORD_WIDTH_DEF = 32;
  localparam int N_WORDS_DEF    = 553;
  localparam int ADDR_WIDTH_DEF = 10;
  localparam int POS_WIDTH_DEF  = 15;
  typedef enum logic [1:0] {IDLE, PRIME, STREAM, DRAIN} state_e;
  typedef logic [5:0] start_t;
endpackage

// File: rtl/rot_word_fetcher_addr_gen.sv
// rot_addr_gen: modular read-address counter, loads (-q-1) mod N_WORDS and wraps N_WORDS-1 -> 0
//   ports: clk, rst_n (sync active-low), load_i + q_i (word offset), inc_i (advance), addr_o
module rot_addr_gen
  import rot_word_fetcher_pkg::*;
#(
  parameter int N_WORDS    = N_WORDS_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] q_i,
  input  logic                  inc_i,
  output logic [ADDR_WIDTH-1:0] addr_o
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(N_WORDS - 1);
  logic [ADDR_WIDTH-1:0] addr_q;
  // q < N_WORDS for any accepted command, so (-q-1) mod N is simply N-1-q
  always_ff @(posedge clk) begin
    if (!rst_n) addr_q <= '0;
    else if (load_i) addr_q <= LAST - q_i;
    else if (inc_i) addr_q <= (addr_q == LAST) ? '0 : addr_q + ADDR_WIDTH'(1);
  end
  assign addr_o = addr_q;
endmodule

// File: rtl/rot_word_fetcher.sv
// rot_word_fetcher: streams rotated word pairs of a cyclic dense polynomial for a sparse bit position
//   ports: clk, rst_n (sync active-low); cmd_valid/cmd_ready/cmd_pos command;
//   mem_rd_en/mem_rd_addr/mem_rd_data 1-cycle synchronous read; out_valid/out_ready beat handshake with
//   out_word_left/right, out_start, out_idx, out_last; busy, err (1-cycle pulse on out-of-range pos).
//   Optional macro ROT_FETCH_DUMMY_EN adds cmd_dummy/out_dummy (dummy pass flag carried on every beat).
module rot_word_fetcher
  import rot_word_fetcher_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int N_WORDS    = N_WORDS_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int POS_WIDTH  = POS_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [POS_WIDTH-1:0]  cmd_pos,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [WORD_WIDTH-1:0] mem_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_word_left,
  output logic [WORD_WIDTH-1:0] out_word_right,
  output start_t                out_start,
  output logic [ADDR_WIDTH-1:0] out_idx,
  output logic                  out_last,
  output logic                  busy,
  output logic                  err
`ifdef ROT_FETCH_DUMMY_EN
  ,
  input  logic                  cmd_dummy,
  output logic                  out_dummy
`endif
);
  state_e                state_q;
  logic [ADDR_WIDTH:0]   rd_left_q;
  logic                  rd_pend_q, first_q, skid_q, out_valid_q, last_q, busy_q, err_q;
  logic [WORD_WIDTH-1:0] prev_q, skid_l_q, skid_r_q, left_q, right_q;
  logic [ADDR_WIDTH-1:0] idx_q, next_idx_q;
  start_t                start_q;
  logic                  accept, bad, arrive, out_free, to_skid, load_out, issue;
  logic [ADDR_WIDTH-1:0] q_w;
  start_t                start_w;
  assign accept   = cmd_valid && state_q == IDLE;
  assign bad      = 32'(cmd_pos) >= 32'(N_WORDS * WORD_WIDTH);
  assign q_w      = ADDR_WIDTH'(cmd_pos / POS_WIDTH'(WORD_WIDTH));
  assign start_w  = start_t'(POS_WIDTH'(WORD_WIDTH) - cmd_pos % POS_WIDTH'(WORD_WIDTH));
  // the first returned word only primes prev_q; every later one completes a beat
  assign arrive   = rd_pend_q && !first_q;
  assign out_free = !out_valid_q || out_ready;
  assign to_skid  = arrive && !out_free;
  assign load_out = out_free && (skid_q || arrive);
  // a read may only go out if its data is guaranteed a home next cycle
  assign issue    = (state_q == PRIME || state_q == STREAM) && !skid_q && !to_skid;
  rot_addr_gen #(.N_WORDS(N_WORDS), .ADDR_WIDTH(ADDR_WIDTH)) u_addr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (accept && !bad),
    .q_i    (q_w),
    .inc_i  (issue),
    .addr_o (mem_rd_addr)
  );
`ifdef ROT_FETCH_DUMMY_EN
  logic dummy_q;
  always_ff @(posedge clk) begin
    if (!rst_n) dummy_q <= 1'b0;
    else if (accept && !bad) dummy_q <= cmd_dummy;
  end
  assign out_dummy = dummy_q;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_left_q   <= '0;
      rd_pend_q   <= 1'b0;
      first_q     <= 1'b0;
      skid_q      <= 1'b0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      prev_q      <= '0;
      skid_l_q    <= '0;
      skid_r_q    <= '0;
      left_q      <= '0;
      right_q     <= '0;
      idx_q       <= '0;
      next_idx_q  <= '0;
      start_q     <= '0;
    end else begin
      err_q     <= accept && bad;
      rd_pend_q <= issue;
      case (state_q)
        IDLE: if (accept && !bad) begin
          state_q    <= PRIME;
          rd_left_q  <= (ADDR_WIDTH+1)'(N_WORDS + 1);
          first_q    <= 1'b1;
          next_idx_q <= '0;
          busy_q     <= 1'b1;
          start_q    <= start_w;
        end
        PRIME, STREAM: if (issue) begin
          rd_left_q <= rd_left_q - (ADDR_WIDTH+1)'(1);
          state_q   <= (rd_left_q == (ADDR_WIDTH+1)'(1)) ? DRAIN : STREAM;
        end
        default: if (out_valid_q && out_ready && last_q) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
      if (rd_pend_q) begin
        prev_q  <= mem_rd_data;
        first_q <= 1'b0;
      end
      if (to_skid) begin
        skid_q   <= 1'b1;
        skid_l_q <= mem_rd_data;
        skid_r_q <= prev_q;
      end else if (load_out) skid_q <= 1'b0;
      if (load_out) begin
        out_valid_q <= 1'b1;
        left_q      <= skid_q ? skid_l_q : mem_rd_data;
        right_q     <= skid_q ? skid_r_q : prev_q;
        idx_q       <= next_idx_q;
        last_q      <= next_idx_q == ADDR_WIDTH'(N_WORDS - 1);
        next_idx_q  <= next_idx_q + ADDR_WIDTH'(1);
      end else if (out_ready) out_valid_q <= 1'b0;
    end
  end
  assign cmd_ready      = state_q == IDLE;
  assign mem_rd_en      = issue;
  assign out_valid      = out_valid_q;
  assign out_word_left  = left_q;
  assign out_word_right = right_q;
  assign out_start      = start_q;
  assign out_idx        = idx_q;
  assign out_last       = last_q;
  assign busy           = busy_q;
  assign err            = err_q;
endmodule

// File: tb/tb_rot_word_fetcher.sv
// tb_rot_word_fetcher: directed self-checking bench for rot_word_fetcher with N_WORDS=4, mem[i]=A0+i
module tb_rot_word_fetcher;
  localparam int W = 32, N = 4, AW = 10, PW = 15;
  logic clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, out_ready = 1'b1;
  logic cmd_ready, mem_rd_en, out_valid, out_last, busy, err;
  logic [PW-1:0] cmd_pos = '0;
  logic [AW-1:0] mem_rd_addr, out_idx;
  logic [W-1:0] mem_rd_data = '0, out_word_left, out_word_right;
  logic [5:0] out_start;
`ifdef ROT_FETCH_DUMMY_EN
  logic cmd_dummy = 1'b0, out_dummy;
`endif
  int checks = 0, failures = 0, cyc = 0;
  rot_word_fetcher #(.N_WORDS(N)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_pos(cmd_pos),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_word_left(out_word_left),
    .out_word_right(out_word_right), .out_start(out_start), .out_idx(out_idx),
    .out_last(out_last), .busy(busy), .err(err)
`ifdef ROT_FETCH_DUMMY_EN
    , .cmd_dummy(cmd_dummy), .out_dummy(out_dummy)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= 32'hA0 + 32'(mem_rd_addr);
  logic [W-1:0] b_left[64], b_right[64], s_left, s_right;
  logic [5:0] b_start[64];
  logic [AW-1:0] b_idx[64], s_idx;
  logic b_last[64], b_dum[64], stalled = 1'b0;
  int b_cyc[64], r_addr[64];
  int bcnt = 0, rcnt = 0, stall_cnt = 0, stab_err = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready && bcnt < 64) begin
        b_left[bcnt]  <= out_word_left;
        b_right[bcnt] <= out_word_right;
        b_start[bcnt] <= out_start;
        b_idx[bcnt]   <= out_idx;
        b_last[bcnt]  <= out_last;
        b_cyc[bcnt]   <= cyc;
`ifdef ROT_FETCH_DUMMY_EN
        b_dum[bcnt]   <= out_dummy;
`else
        b_dum[bcnt]   <= 1'b0;
`endif
        bcnt <= bcnt + 1;
      end
      if (stalled && (!out_valid || out_word_left != s_left || out_word_right != s_right || out_idx != s_idx))
        stab_err <= stab_err + 1;
      if (out_valid && !out_ready) stall_cnt <= stall_cnt + 1;
      stalled <= out_valid && !out_ready;
      s_left  <= out_word_left;
      s_right <= out_word_right;
      s_idx   <= out_idx;
      if (mem_rd_en && rcnt < 64) begin
        r_addr[rcnt] <= int'(mem_rd_addr);
        rcnt <= rcnt + 1;
      end
    end else stalled <= 1'b0;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int md(input int i);
    return ((i % N) + N) % N;
  endfunction
  task automatic send(input int pos, output int t);
    @(posedge clk) #1;
    cmd_pos = PW'(pos);
    cmd_valid = 1'b1;
    t = cyc + 1;
    @(posedge clk) #1;
    cmd_valid = 1'b0;
  endtask
  task automatic wait_done(input string tag, input int base);
    int w = 0;
    while (bcnt < base + N && w < 200) begin @(posedge clk) #1; w++; end
    chk({tag, "_nbeats"}, 64'(bcnt - base), 64'(N));
    w = 0;
    while (busy && w < 50) begin @(posedge clk) #1; w++; end
    @(posedge clk) #1;
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    chk({tag, "_idle_ready"}, 64'(cmd_ready), 64'd1);
    chk({tag, "_no_extra"}, 64'(bcnt - base), 64'(N));
  endtask
  task automatic check_pass(input string tag, input int base, input int rbase, input int pos,
                            input bit timed, input int t, input bit dum);
    int q = pos / W, r = pos % W;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s_b%0d_left", tag, k), 64'(b_left[base+k]), 64'(32'hA0 + md(k - q)));
      chk($sformatf("%s_b%0d_right", tag, k), 64'(b_right[base+k]), 64'(32'hA0 + md(k - q - 1)));
      chk($sformatf("%s_b%0d_start", tag, k), 64'(b_start[base+k]), 64'(W - r));
      chk($sformatf("%s_b%0d_idx", tag, k), 64'(b_idx[base+k]), 64'(k));
      chk($sformatf("%s_b%0d_last", tag, k), 64'(b_last[base+k]), 64'(k == N - 1));
      chk($sformatf("%s_b%0d_dummy", tag, k), 64'(b_dum[base+k]), 64'(dum));
      if (timed) chk($sformatf("%s_b%0d_cycle", tag, k), 64'(b_cyc[base+k]), 64'(t + 3 + k));
    end
    chk({tag, "_nreads"}, 64'(rcnt - rbase), 64'(N + 1));
    for (int k = 0; k <= N; k++)
      chk($sformatf("%s_rd%0d_addr", tag, k), 64'(r_addr[rbase+k]), 64'(md(k - q - 1)));
  endtask
  initial begin
    int t, base, rbase, sc, w;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_outs", {out_word_left, out_word_right}, 64'd0);
    chk("rst_meta", 64'({out_start, out_idx, out_last}), 64'd0);
    @(posedge clk) #1;
    rst_n = 1'b1;
    // pos=0, ready held high
    base = bcnt; rbase = rcnt;
    send(0, t);
    @(negedge clk);
    chk("p0_busy_after_accept", 64'(busy), 64'd1);
    chk("p0_cmd_ready_low", 64'(cmd_ready), 64'd0);
    wait_done("p0", base);
    chk("p0_b0_left_const", 64'(b_left[base]), 64'hA0);
    chk("p0_b0_right_const", 64'(b_right[base]), 64'hA3);
    chk("p0_b3_left_const", 64'(b_left[base+3]), 64'hA3);
    chk("p0_b3_right_const", 64'(b_right[base+3]), 64'hA2);
    check_pass("p0", base, rbase, 0, 1'b1, t, 1'b0);
    // pos=33 -> q=1, r=1
    base = bcnt; rbase = rcnt;
    send(33, t);
    wait_done("p33", base);
    chk("p33_b0_left_const", 64'(b_left[base]), 64'hA3);
    chk("p33_b0_right_const", 64'(b_right[base]), 64'hA2);
    chk("p33_b0_start_const", 64'(b_start[base]), 64'd31);
    chk("p33_b1_left_const", 64'(b_left[base+1]), 64'hA0);
    chk("p33_b1_right_const", 64'(b_right[base+1]), 64'hA3);
    chk("p33_rd_addrs_const", 64'({r_addr[rbase][3:0], r_addr[rbase+1][3:0], r_addr[rbase+2][3:0],
                                   r_addr[rbase+3][3:0], r_addr[rbase+4][3:0]}), 64'h23012);
    check_pass("p33", base, rbase, 33, 1'b1, t, 1'b0);
    // pos=5 with out_ready toggling every cycle
    base = bcnt; rbase = rcnt; sc = stall_cnt;
    send(5, t);
    w = 0;
    while (bcnt < base + N && w < 200) begin @(posedge clk) #1; out_ready = ~out_ready; w++; end
    out_ready = 1'b1;
    wait_done("p5", base);
    chk("p5_stalls_seen", 64'(stall_cnt > sc), 64'd1);
    chk("p5_stable_under_stall", 64'(stab_err), 64'd0);
    check_pass("p5", base, rbase, 5, 1'b0, t, 1'b0);
    // out-of-range position
    base = bcnt; rbase = rcnt;
    send(128, t);
    @(negedge clk);
    chk("bad_err_pulse", 64'(err), 64'd1);
    chk("bad_busy", 64'(busy), 64'd0);
    chk("bad_cmd_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    chk("bad_err_cleared", 64'(err), 64'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("bad_no_reads", 64'(rcnt - rbase), 64'd0);
    chk("bad_no_beats", 64'(bcnt - base), 64'd0);
    // reset in the middle of a pass
    base = bcnt;
    send(0, t);
    w = 0;
    while (bcnt < base + 2 && w < 100) begin @(posedge clk) #1; w++; end
    chk("mid_two_beats", 64'(bcnt - base), 64'd2);
    rst_n = 1'b0;
    @(posedge clk) #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_out_valid", 64'(out_valid), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_cmd_ready", 64'(cmd_ready), 64'd1);
    repeat (8) @(posedge clk);
    #1;
    chk("mid_no_more_beats", 64'(bcnt - base), 64'd2);
    base = bcnt; rbase = rcnt;
    send(0, t);
    wait_done("post", base);
    check_pass("post", base, rbase, 0, 1'b1, t, 1'b0);
`ifdef ROT_FETCH_DUMMY_EN
    base = bcnt; rbase = rcnt;
    cmd_dummy = 1'b1;
    send(0, t);
    cmd_dummy = 1'b0;
    wait_done("dum", base);
    check_pass("dum", base, rbase, 0, 1'b1, t, 1'b1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rot_word_fetcher.md
ROT_WORD_FETCHER -- requirements
Module: rot_word_fetcher

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32: dense polynomial word width.
REQ-002 SHALL have parameter N_WORDS, default 553: words per cyclic polynomial, polynomial length N_WORDS*WORD_WIDTH bits.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10: word address width.
REQ-004 SHALL have parameter POS_WIDTH, default 15: sparse bit-position width.
REQ-005 SHALL have clk  in  1: single clock; all logic on rising edge.
REQ-006 SHALL have rst_n  in  1: synchronous, active-low reset.
REQ-007 SHALL have cmd_valid in 1, cmd_ready out 1, cmd_pos in POS_WIDTH: rotation command (sparse bit position).
REQ-008 SHALL have mem_rd_en out 1, mem_rd_addr out ADDR_WIDTH, mem_rd_data in WORD_WIDTH: synchronous read port, data valid one cycle after mem_rd_en.
REQ-009 SHALL have out_valid out 1, out_ready in 1: output beat handshake.
REQ-010 SHALL have out_word_left/out_word_right out WORD_WIDTH, out_start out 6, out_idx out ADDR_WIDTH, out_last out 1: word pair, window start, and destination word index consumed by the XOR/shift adder.
REQ-011 SHALL have busy out 1 (pass active) and err out 1 (one-cycle pulse).

Function
REQ-012 SHALL accept a command when cmd_valid && cmd_ready; cmd_ready = 1 only in IDLE.
REQ-013 SHALL split cmd_pos as q = pos / WORD_WIDTH, r = pos % WORD_WIDTH.
REQ-014 SHALL emit beats k = 0..N_WORDS-1 in order: out_word_left = mem[(k-q) mod N_WORDS], out_word_right = mem[(k-q-1) mod N_WORDS], out_start = WORD_WIDTH-r (32 when r=0), out_idx = k, out_last = (k == N_WORDS-1).
REQ-015 SHALL issue exactly N_WORDS+1 reads per pass, addresses (-q-1), (-q), (-q+1), ... mod N_WORDS, with wrap N_WORDS-1 -> 0 and no divider (modular decrement/increment counters only).
REQ-016 SHALL use states IDLE -> PRIME (first read) -> STREAM (one read per accepted/free slot) -> DRAIN (final beat pending) -> IDLE after last beat accepted.
REQ-017 Latency: accept at cycle t, reads at t+1 and t+2, first out_valid at t+3; with out_ready held high, one beat per cycle, out_last at t+2+N_WORDS.
REQ-018 SHALL hold out_* stable while out_valid && !out_ready.
REQ-019 SHALL include a one-entry skid register capturing read data returned while the output stalls; no read SHALL be issued while the skid register is full; no beat lost or duplicated.
REQ-020 SHALL treat cmd_pos >= N_WORDS*WORD_WIDTH as invalid: accept, pulse err the next cycle, issue no reads or beats, stay IDLE.
REQ-021 SHALL keep busy = 1 from the accept cycle +1 until the cycle after the last beat handshake.

Reset
REQ-022 On rst_n = 0 at a clock edge: state IDLE, cmd_ready 1 after release, out_valid 0, mem_rd_en 0, busy 0, err 0, out_word_*/out_start/out_idx/out_last 0, skid empty.
REQ-023 Reset mid-pass SHALL abandon the pass with no further beats; a read returning after reset SHALL be ignored.

Configuration
REQ-024 Macro ROT_FETCH_DUMMY_EN: when defined, input cmd_dummy and output out_dummy exist; cmd_dummy is latched on accept and driven on out_dummy for every beat of that pass; reads, timing and handshakes identical to a real pass.
REQ-025 Without ROT_FETCH_DUMMY_EN: neither port exists and behaviour is REQ-012..REQ-023 unchanged.

Structure
REQ-026 Shared package SHALL hold the FSM state enum, WORD_WIDTH/N_WORDS/ADDR_WIDTH/POS_WIDTH defaults, and the 6-bit start-offset type.
REQ-027 SHALL instantiate one sub-module, rot_addr_gen (modular address counter with load-negated-q and wrap), everything else inline.

Verification (N_WORDS = 4, mem[i] = 32'hA0+i)
REQ-028 pos=0, out_ready=1 -> 4 beats in consecutive cycles, beat0 left=A0 right=A3 start=32, beat3 left=A3 right=A2 out_last=1.
REQ-029 pos=33 -> q=1, r=1: beat0 left=A3 right=A2 start=31, beat1 left=A0 right=A3; 5 reads at addrs 2,3,0,1,2.
REQ-030 pos=5, out_ready toggled 1/0 each cycle -> same 4 beats as ready=1 case, stable under stall, no loss/duplicate.
REQ-031 pos=128 -> err pulse 1 cycle, zero reads, zero beats, cmd_ready back to 1.
REQ-032 rst_n=0 after beat1 -> out_valid/busy 0 next cycle, no further beats; new pos=0 command then runs normally.
REQ-033 ROT_FETCH_DUMMY_EN, cmd_dummy=1, pos=0 -> beats identical to REQ-028 with out_dummy=1 on all 4.
